// File: rtl/usb_line_pkg.sv
// Shared encodings and limits for the USB full/low-speed line receiver.
// Line-state codes match the line_state output of usb_fs_line_rx.
package usb_line_pkg;

    typedef enum logic [1:0] {
        LS_SE0 = 2'd0,
        LS_J   = 2'd1,
        LS_K   = 2'd2,
        LS_SE1 = 2'd3
    } line_t;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SYNC     = 3'd1,
        ST_DATA     = 3'd2,
        ST_EOP      = 3'd3,
        ST_ERR_WAIT = 3'd4
    } rx_state_t;

    localparam int STUFF_ONES       = 6;
    localparam int SYNC_ZERO_SAT    = 7;
    localparam int EOP_MAX_SE0_BITS = 3;
    localparam int ERR_J_BITS       = 2;

    // j_is_p: 1 when J is D+ high (full speed), 0 when J is D- high (low speed)
    function automatic line_t decode_line(input logic p, input logic m, input logic j_is_p);
        line_t ls;
        case ({p, m})
            2'b00:   ls = LS_SE0;
            2'b11:   ls = LS_SE1;
            2'b10:   ls = j_is_p ? LS_J : LS_K;
            default: ls = j_is_p ? LS_K : LS_J;
        endcase
        return ls;
    endfunction

endpackage

// File: rtl/usb_nrzi_unstuff.sv
// NRZI decoder and bit unstuffer: one decision per J/K sample strobe.
// level is 1 for J, 0 for K; stuffed zeros are dropped by deasserting bit_valid.
module usb_nrzi_unstuff
    import usb_line_pkg::*;
(
    input  logic clk,
    input  logic nreset,
    input  logic clear,
    input  logic strobe,
    input  logic level,
    output logic dec_bit,
    output logic bit_valid,
    output logic stuff_error
);

    logic       prev_level;
    logic [2:0] ones;
    logic       at_limit;

    assign dec_bit     = (level == prev_level);
    assign at_limit    = (ones == 3'(STUFF_ONES));
    assign bit_valid   = strobe && !(at_limit && !dec_bit);
    assign stuff_error = strobe && at_limit && dec_bit;

    // The ones run keeps counting through IDLE and SYNC; the zeros of SYNC
    // clear it, so the trailing SYNC one starts the run for the data field.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            prev_level <= 1'b1;
            ones       <= 3'd0;
        end else if (clear) begin
            prev_level <= 1'b1;
            ones       <= 3'd0;
        end else if (strobe) begin
            prev_level <= level;
            if (dec_bit && !at_limit) begin
                ones <= ones + 3'd1;
            end else begin
                ones <= 3'd0;
            end
        end
    end

endmodule

// File: rtl/usb_fs_line_rx.sv
// USB line receiver: synchronizer, bit-phase recovery, SYNC/NRZI/unstuff/EOP framing.
// Optional SE0 bus-reset detector is built when USB_FS_LINE_RX_BUS_RESET_EN is defined.
module usb_fs_line_rx
    import usb_line_pkg::*;
#(
    parameter int CLKS_PER_BIT   = 4,
    parameter int FULLSPEED      = 1,
    parameter int MIN_SYNC_ZEROS = 3,
    parameter int RESET_CYCLES   = 480
) (
    input  logic       clk,
    input  logic       nreset,
    input  logic       linep,
    input  logic       linem,
    input  logic       enable,
    output logic [1:0] line_state,
    output logic       rx_active,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_eop,
    output logic       rx_error
`ifdef USB_FS_LINE_RX_BUS_RESET_EN
    ,
    output logic       bus_reset
`endif
);

    localparam logic J_P = (FULLSPEED != 0);
    localparam int PH_W = $clog2(CLKS_PER_BIT);
    localparam logic [PH_W-1:0] PH_LAST   = PH_W'(CLKS_PER_BIT - 1);
    localparam logic [PH_W-1:0] PH_SAMPLE = PH_W'(CLKS_PER_BIT / 2 - 1);

    if (CLKS_PER_BIT < 4 || (CLKS_PER_BIT % 2) != 0 || RESET_CYCLES < 1) begin : g_param_check
        $error("usb_fs_line_rx: CLKS_PER_BIT must be even and >= 4, RESET_CYCLES >= 1");
    end

    logic p_s1, p_s2, m_s1, m_s2;
    line_t ls, ls_prev;
    logic [PH_W-1:0] phase, phase_cur;
    logic jk_edge, sample, jk_strobe;
    logic dec_bit, bit_valid, stuff_error;
    logic br_hit;

    rx_state_t state, state_n;
    logic [2:0] zeros, zeros_n;
    logic [2:0] bit_cnt, bit_cnt_n;
    logic [7:0] shift, shift_n;
    logic [1:0] se0_bits, se0_bits_n;
    logic [1:0] j_bits, j_bits_n;
    logic       eop_bad, eop_bad_n;
    logic [7:0] data_n;
    logic       valid_n, eop_n, err_n;

    // An undriven (X/Z) line leaves the first stage holding its last value.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            p_s1 <= J_P;
            p_s2 <= J_P;
            m_s1 <= !J_P;
            m_s2 <= !J_P;
        end else begin
            if (linep == 1'b1) p_s1 <= 1'b1;
            else if (linep == 1'b0) p_s1 <= 1'b0;
            if (linem == 1'b1) m_s1 <= 1'b1;
            else if (linem == 1'b0) m_s1 <= 1'b0;
            p_s2 <= p_s1;
            m_s2 <= m_s1;
        end
    end

    assign ls         = decode_line(p_s2, m_s2, J_P);
    assign line_state = ls;

    // Bit phase restarts on the first cycle of every J/K edge; sampling sits mid-bit.
    assign jk_edge   = ((ls == LS_J) && (ls_prev == LS_K)) || ((ls == LS_K) && (ls_prev == LS_J));
    assign phase_cur = jk_edge ? '0 : phase;
    assign sample    = enable && (phase_cur == PH_SAMPLE);
    assign jk_strobe = sample && ((ls == LS_J) || (ls == LS_K));

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            ls_prev <= LS_J;
            phase   <= '0;
        end else begin
            ls_prev <= ls;
            phase   <= (phase_cur == PH_LAST) ? '0 : phase_cur + 1'b1;
        end
    end

    usb_nrzi_unstuff u_nrzi_unstuff (
        .clk         (clk),
        .nreset      (nreset),
        .clear       (!enable),
        .strobe      (jk_strobe),
        .level       (ls == LS_J),
        .dec_bit     (dec_bit),
        .bit_valid   (bit_valid),
        .stuff_error (stuff_error)
    );

`ifdef USB_FS_LINE_RX_BUS_RESET_EN
    localparam int SE0_W = $clog2(RESET_CYCLES + 1);
    logic [SE0_W-1:0] se0_run;

    assign br_hit = (ls == LS_SE0) && (se0_run == SE0_W'(RESET_CYCLES - 1));

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            se0_run   <= '0;
            bus_reset <= 1'b0;
        end else if (ls != LS_SE0) begin
            se0_run   <= '0;
            bus_reset <= 1'b0;
        end else begin
            if (se0_run != SE0_W'(RESET_CYCLES)) se0_run <= se0_run + 1'b1;
            if (br_hit) bus_reset <= 1'b1;
        end
    end
`else
    assign br_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) state <= ST_IDLE;
        else         state <= state_n;
    end

    always_comb begin
        state_n    = state;
        zeros_n    = zeros;
        bit_cnt_n  = bit_cnt;
        shift_n    = shift;
        se0_bits_n = se0_bits;
        j_bits_n   = j_bits;
        eop_bad_n  = eop_bad;
        data_n     = rx_data;
        valid_n    = 1'b0;
        eop_n      = 1'b0;
        err_n      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (sample && (ls == LS_K)) begin
                    state_n = ST_SYNC;
                    zeros_n = 3'd1;
                end
            end
            ST_SYNC: begin
                if (sample) begin
                    if (ls == LS_SE0) begin
                        state_n = ST_IDLE;
                    end else if (ls == LS_SE1) begin
                        state_n  = ST_ERR_WAIT;
                        j_bits_n = 2'd0;
                    end else if (!dec_bit) begin
                        zeros_n = (zeros == 3'(SYNC_ZERO_SAT)) ? zeros : zeros + 3'd1;
                    end else if (int'(zeros) >= MIN_SYNC_ZEROS) begin
                        state_n   = ST_DATA;
                        bit_cnt_n = 3'd0;
                    end else begin
                        state_n  = ST_ERR_WAIT;
                        j_bits_n = 2'd0;
                    end
                end
            end
            ST_DATA: begin
                if (sample) begin
                    if (ls == LS_SE0) begin
                        state_n    = ST_EOP;
                        se0_bits_n = 2'd1;
                        eop_bad_n  = (bit_cnt != 3'd0);
                    end else if ((ls == LS_SE1) || stuff_error) begin
                        err_n    = 1'b1;
                        state_n  = ST_ERR_WAIT;
                        j_bits_n = 2'd0;
                    end else if (bit_valid) begin
                        shift_n   = {dec_bit, shift[7:1]};
                        bit_cnt_n = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            data_n  = shift_n;
                            valid_n = 1'b1;
                        end
                    end
                end
            end
            ST_EOP: begin
                if (sample) begin
                    if (ls == LS_J) begin
                        eop_n   = 1'b1;
                        err_n   = eop_bad;
                        state_n = ST_IDLE;
                    end else if ((ls == LS_SE0) && (se0_bits != 2'(EOP_MAX_SE0_BITS))) begin
                        se0_bits_n = se0_bits + 2'd1;
                    end else begin
                        err_n    = 1'b1;
                        state_n  = ST_ERR_WAIT;
                        j_bits_n = 2'd0;
                    end
                end
            end
            ST_ERR_WAIT: begin
                if (sample) begin
                    if (ls != LS_J) begin
                        j_bits_n = 2'd0;
                    end else if (j_bits == 2'(ERR_J_BITS - 1)) begin
                        state_n = ST_IDLE;
                    end else begin
                        j_bits_n = j_bits + 2'd1;
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase
        if (br_hit || !enable) begin
            state_n   = ST_IDLE;
            valid_n   = 1'b0;
            eop_n     = 1'b0;
            err_n     = 1'b0;
            zeros_n   = 3'd0;
            bit_cnt_n = 3'd0;
            j_bits_n  = 2'd0;
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            zeros    <= 3'd0;
            bit_cnt  <= 3'd0;
            shift    <= 8'd0;
            se0_bits <= 2'd0;
            j_bits   <= 2'd0;
            eop_bad  <= 1'b0;
            rx_data  <= 8'd0;
            rx_valid <= 1'b0;
            rx_eop   <= 1'b0;
            rx_error <= 1'b0;
        end else begin
            zeros    <= zeros_n;
            bit_cnt  <= bit_cnt_n;
            shift    <= shift_n;
            se0_bits <= se0_bits_n;
            j_bits   <= j_bits_n;
            eop_bad  <= eop_bad_n;
            rx_data  <= data_n;
            rx_valid <= valid_n;
            rx_eop   <= eop_n;
            rx_error <= err_n;
        end
    end

    assign rx_active = (state == ST_DATA) || (state == ST_EOP);

endmodule

// File: tb/tb_usb_fs_line_rx.sv
// Directed bench for usb_fs_line_rx: a bit-level USB transmitter model drives the
// line pair, a negedge monitor collects strobes, scenario tasks compare the results.
module tb_usb_fs_line_rx;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       nreset = 1'b0;
    logic       linep = 1'b1;
    logic       linem = 1'b0;
    logic       enable = 1'b0;
    logic [1:0] line_state;
    logic       rx_active;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_eop;
    logic       rx_error;
`ifdef USB_FS_LINE_RX_BUS_RESET_EN
    logic       bus_reset;
`endif

    int checks = 0;
    int passed = 0;

    usb_fs_line_rx dut (
        .clk        (clk),
        .nreset     (nreset),
        .linep      (linep),
        .linem      (linem),
        .enable     (enable),
        .line_state (line_state),
        .rx_active  (rx_active),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_eop     (rx_eop),
        .rx_error   (rx_error)
`ifdef USB_FS_LINE_RX_BUS_RESET_EN
        ,
        .bus_reset  (bus_reset)
`endif
    );

    always #5 clk = ~clk;

    // ---------------- monitor ----------------
    logic [7:0] got_q[$];
    int eop_cnt = 0;
    int err_cnt = 0;
    int both_cnt = 0;
    int clash_cnt = 0;
    int active_cnt = 0;

    always @(negedge clk) begin
        if (rx_valid) got_q.push_back(rx_data);
        if (rx_eop) eop_cnt++;
        if (rx_error) err_cnt++;
        if (rx_eop && rx_error) both_cnt++;
        if (rx_valid && rx_eop) clash_cnt++;
        if (rx_active) active_cnt++;
    end

    // ---------------- transmitter model ----------------
    logic cur_k = 1'b0;
    int   ones = 0;

    task automatic drive_level(input logic [1:0] lvl);
        case (lvl)
            2'd0:    {linep, linem} = 2'b00;
            2'd1:    {linep, linem} = 2'b10;
            2'd2:    {linep, linem} = 2'b01;
            default: {linep, linem} = 2'b11;
        endcase
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_nrzi(input logic b);
        if (!b) cur_k = !cur_k;
        drive_level(cur_k ? 2'd2 : 2'd1);
    endtask

    task automatic idle_bits(input int n);
        cur_k = 1'b0;
        repeat (n) drive_level(2'd1);
    endtask

    task automatic send_sync();
        cur_k = 1'b0;
        repeat (7) send_nrzi(1'b0);
        send_nrzi(1'b1);
        ones = 1;
    endtask

    task automatic send_data_bit(input logic b, input logic corrupt);
        send_nrzi(b);
        ones = b ? ones + 1 : 0;
        if (ones == 6) begin
            send_nrzi(corrupt);
            ones = 0;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic corrupt);
        for (int i = 0; i < 8; i++) send_data_bit(b[i], corrupt);
    endtask

    task automatic send_eop();
        drive_level(2'd0);
        drive_level(2'd0);
        drive_level(2'd1);
        idle_bits(4);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        nreset = 1'b0;
        enable = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (line_state !== 2'd1) $display("FAIL reset_line_state: got %0d expected 1", line_state); else passed++;
        checks++; if (rx_active !== 1'b0) $display("FAIL reset_rx_active: got %b expected 0", rx_active); else passed++;
        checks++; if (rx_data !== 8'h00) $display("FAIL reset_rx_data: got %h expected 00", rx_data); else passed++;
        checks++; if (rx_valid !== 1'b0) $display("FAIL reset_rx_valid: got %b expected 0", rx_valid); else passed++;
        checks++; if (rx_eop !== 1'b0) $display("FAIL reset_rx_eop: got %b expected 0", rx_eop); else passed++;
        checks++; if (rx_error !== 1'b0) $display("FAIL reset_rx_error: got %b expected 0", rx_error); else passed++;
        nreset = 1'b1;
        @(negedge clk);
    endtask

    // Receiver disabled here so the FSM stays idle while the decode is probed.
    task automatic test_line_state();
        {linep, linem} = 2'b01;
        @(negedge clk);
        checks++; if (line_state !== 2'd1) $display("FAIL ls_latency_1cyc: got %0d expected 1", line_state); else passed++;
        @(negedge clk);
        checks++; if (line_state !== 2'd2) $display("FAIL ls_k: got %0d expected 2", line_state); else passed++;
        {linep, linem} = 2'b00;
        repeat (2) @(negedge clk);
        checks++; if (line_state !== 2'd0) $display("FAIL ls_se0: got %0d expected 0", line_state); else passed++;
        {linep, linem} = 2'b11;
        repeat (2) @(negedge clk);
        checks++; if (line_state !== 2'd3) $display("FAIL ls_se1: got %0d expected 3", line_state); else passed++;
        {linep, linem} = 2'b10;
        repeat (2) @(negedge clk);
        checks++; if (line_state !== 2'd1) $display("FAIL ls_j: got %0d expected 1", line_state); else passed++;
        enable = 1'b1;
        idle_bits(4);
    endtask

    task automatic test_clean_packet();
        int base = got_q.size();
        int e0 = eop_cnt, r0 = err_cnt, c0 = clash_cnt, a0 = active_cnt;
        logic [7:0] b;
        send_sync();
        send_byte(8'hA5, 1'b0);
        send_byte(8'h12, 1'b0);
        send_byte(8'h34, 1'b0);
        send_eop();
        checks++; if (got_q.size() - base !== 3) $display("FAIL clean_count: got %0d expected 3", got_q.size() - base); else passed++;
        b = (got_q.size() > base) ? got_q[base] : 8'hxx;
        checks++; if (b !== 8'hA5) $display("FAIL clean_byte0: got %h expected a5", b); else passed++;
        b = (got_q.size() > base + 1) ? got_q[base + 1] : 8'hxx;
        checks++; if (b !== 8'h12) $display("FAIL clean_byte1: got %h expected 12", b); else passed++;
        b = (got_q.size() > base + 2) ? got_q[base + 2] : 8'hxx;
        checks++; if (b !== 8'h34) $display("FAIL clean_byte2: got %h expected 34", b); else passed++;
        checks++; if (eop_cnt - e0 !== 1) $display("FAIL clean_eop: got %0d expected 1", eop_cnt - e0); else passed++;
        checks++; if (err_cnt - r0 !== 0) $display("FAIL clean_error: got %0d expected 0", err_cnt - r0); else passed++;
        checks++; if (clash_cnt - c0 !== 0) $display("FAIL clean_valid_eop_clash: got %0d expected 0", clash_cnt - c0); else passed++;
        checks++; if (active_cnt - a0 < 100) $display("FAIL clean_active_cycles: got %0d expected >=100", active_cnt - a0); else passed++;
        checks++; if (rx_active !== 1'b0) $display("FAIL clean_active_after: got %b expected 0", rx_active); else passed++;
    endtask

    task automatic test_stuffing();
        int base = got_q.size();
        int e0 = eop_cnt, r0 = err_cnt;
        logic [7:0] b;
        send_sync();
        send_byte(8'hFF, 1'b0);
        send_byte(8'h3F, 1'b0);
        send_eop();
        checks++; if (got_q.size() - base !== 2) $display("FAIL stuff_count: got %0d expected 2", got_q.size() - base); else passed++;
        b = (got_q.size() > base) ? got_q[base] : 8'hxx;
        checks++; if (b !== 8'hFF) $display("FAIL stuff_byte0: got %h expected ff", b); else passed++;
        b = (got_q.size() > base + 1) ? got_q[base + 1] : 8'hxx;
        checks++; if (b !== 8'h3F) $display("FAIL stuff_byte1: got %h expected 3f", b); else passed++;
        checks++; if (eop_cnt - e0 !== 1) $display("FAIL stuff_eop: got %0d expected 1", eop_cnt - e0); else passed++;
        checks++; if (err_cnt - r0 !== 0) $display("FAIL stuff_error_clean: got %0d expected 0", err_cnt - r0); else passed++;

        base = got_q.size();
        e0 = eop_cnt;
        r0 = err_cnt;
        send_sync();
        send_byte(8'hFF, 1'b1);
        send_byte(8'h3F, 1'b0);
        send_eop();
        checks++; if (err_cnt - r0 !== 1) $display("FAIL stuffbad_error: got %0d expected 1", err_cnt - r0); else passed++;
        checks++; if (got_q.size() - base !== 0) $display("FAIL stuffbad_valid: got %0d expected 0", got_q.size() - base); else passed++;
        checks++; if (eop_cnt - e0 !== 0) $display("FAIL stuffbad_eop: got %0d expected 0", eop_cnt - e0); else passed++;
        idle_bits(4);
    endtask

    task automatic test_truncated();
        int base = got_q.size();
        int e0 = eop_cnt, r0 = err_cnt, t0 = both_cnt;
        logic [7:0] b;
        logic [4:0] tail = 5'b10101;
        send_sync();
        send_byte(8'hC3, 1'b0);
        for (int i = 0; i < 5; i++) send_data_bit(tail[i], 1'b0);
        send_eop();
        checks++; if (got_q.size() - base !== 1) $display("FAIL trunc_count: got %0d expected 1", got_q.size() - base); else passed++;
        b = (got_q.size() > base) ? got_q[base] : 8'hxx;
        checks++; if (b !== 8'hC3) $display("FAIL trunc_byte: got %h expected c3", b); else passed++;
        checks++; if (eop_cnt - e0 !== 1) $display("FAIL trunc_eop: got %0d expected 1", eop_cnt - e0); else passed++;
        checks++; if (err_cnt - r0 !== 1) $display("FAIL trunc_error: got %0d expected 1", err_cnt - r0); else passed++;
        checks++; if (both_cnt - t0 !== 1) $display("FAIL trunc_eop_with_error: got %0d expected 1", both_cnt - t0); else passed++;
    endtask

    task automatic test_short_sync();
        int base = got_q.size();
        int e0 = eop_cnt, r0 = err_cnt, a0 = active_cnt;
        logic [7:0] b;
        cur_k = 1'b0;
        send_nrzi(1'b0);
        send_nrzi(1'b0);
        send_nrzi(1'b1);
        idle_bits(6);
        checks++; if (active_cnt - a0 !== 0) $display("FAIL short_active: got %0d expected 0", active_cnt - a0); else passed++;
        checks++; if (got_q.size() - base + eop_cnt - e0 + err_cnt - r0 !== 0)
            $display("FAIL short_strobes: got %0d expected 0", got_q.size() - base + eop_cnt - e0 + err_cnt - r0); else passed++;
        send_sync();
        send_byte(8'h5A, 1'b0);
        send_eop();
        b = (got_q.size() > base) ? got_q[base] : 8'hxx;
        checks++; if (b !== 8'h5A) $display("FAIL short_next_byte: got %h expected 5a", b); else passed++;
        checks++; if (eop_cnt - e0 !== 1) $display("FAIL short_next_eop: got %0d expected 1", eop_cnt - e0); else passed++;
    endtask

    task automatic test_reset_abort();
        int base = got_q.size();
        int base2, e0, r0;
        logic [7:0] b;
        send_sync();
        send_byte(8'hA5, 1'b0);
        for (int i = 0; i < 4; i++) send_data_bit(1'(i == 1), 1'b0);
        checks++; if (rx_active !== 1'b1) $display("FAIL rstab_active_before: got %b expected 1", rx_active); else passed++;
        nreset = 1'b0;
        {linep, linem} = 2'b10;
        #1;
        checks++; if (rx_active !== 1'b0) $display("FAIL rstab_active: got %b expected 0", rx_active); else passed++;
        checks++; if (rx_data !== 8'h00) $display("FAIL rstab_data: got %h expected 00", rx_data); else passed++;
        checks++; if (line_state !== 2'd1) $display("FAIL rstab_line_state: got %0d expected 1", line_state); else passed++;
        base2 = got_q.size();
        e0 = eop_cnt;
        r0 = err_cnt;
        repeat (3) @(negedge clk);
        nreset = 1'b1;
        idle_bits(6);
        checks++; if (got_q.size() - base2 + eop_cnt - e0 + err_cnt - r0 !== 0)
            $display("FAIL rstab_strobes: got %0d expected 0", got_q.size() - base2 + eop_cnt - e0 + err_cnt - r0); else passed++;
        send_sync();
        send_byte(8'h77, 1'b0);
        send_eop();
        checks++; if (got_q.size() - base !== 2) $display("FAIL rstab_total: got %0d expected 2", got_q.size() - base); else passed++;
        b = (got_q.size() > base + 1) ? got_q[base + 1] : 8'hxx;
        checks++; if (b !== 8'h77) $display("FAIL rstab_next_byte: got %h expected 77", b); else passed++;
        checks++; if (eop_cnt - e0 !== 1) $display("FAIL rstab_next_eop: got %0d expected 1", eop_cnt - e0); else passed++;
    endtask

    task automatic test_enable_abort();
        int base = got_q.size();
        int base2, e0, r0;
        logic [7:0] b;
        send_sync();
        send_byte(8'hA5, 1'b0);
        for (int i = 0; i < 4; i++) send_data_bit(1'(i == 1), 1'b0);
        enable = 1'b0;
        {linep, linem} = 2'b10;
        base2 = got_q.size();
        e0 = eop_cnt;
        r0 = err_cnt;
        @(negedge clk);
        checks++; if (rx_active !== 1'b0) $display("FAIL enab_active: got %b expected 0", rx_active); else passed++;
        repeat (3 * CPB) @(negedge clk);
        enable = 1'b1;
        idle_bits(6);
        checks++; if (got_q.size() - base2 + eop_cnt - e0 + err_cnt - r0 !== 0)
            $display("FAIL enab_strobes: got %0d expected 0", got_q.size() - base2 + eop_cnt - e0 + err_cnt - r0); else passed++;
        send_sync();
        send_byte(8'h81, 1'b0);
        send_eop();
        checks++; if (got_q.size() - base !== 2) $display("FAIL enab_total: got %0d expected 2", got_q.size() - base); else passed++;
        b = (got_q.size() > base + 1) ? got_q[base + 1] : 8'hxx;
        checks++; if (b !== 8'h81) $display("FAIL enab_next_byte: got %h expected 81", b); else passed++;
        checks++; if (eop_cnt - e0 !== 1) $display("FAIL enab_next_eop: got %0d expected 1", eop_cnt - e0); else passed++;
    endtask

    task automatic test_long_se0();
        int base = got_q.size();
        int e0 = eop_cnt, r0 = err_cnt, a0 = active_cnt;
        logic [7:0] b;
        {linep, linem} = 2'b00;
`ifdef USB_FS_LINE_RX_BUS_RESET_EN
        repeat (481) @(negedge clk);
        checks++; if (bus_reset !== 1'b0) $display("FAIL busrst_early: got %b expected 0", bus_reset); else passed++;
        @(negedge clk);
        checks++; if (bus_reset !== 1'b1) $display("FAIL busrst_rise: got %b expected 1", bus_reset); else passed++;
        repeat (18) @(negedge clk);
        checks++; if (bus_reset !== 1'b1) $display("FAIL busrst_hold: got %b expected 1", bus_reset); else passed++;
        {linep, linem} = 2'b10;
        repeat (3) @(negedge clk);
        checks++; if (bus_reset !== 1'b0) $display("FAIL busrst_fall: got %b expected 0", bus_reset); else passed++;
`else
        repeat (500) @(negedge clk);
        {linep, linem} = 2'b10;
`endif
        idle_bits(6);
        checks++; if (active_cnt - a0 !== 0) $display("FAIL longse0_active: got %0d expected 0", active_cnt - a0); else passed++;
        checks++; if (got_q.size() - base + eop_cnt - e0 + err_cnt - r0 !== 0)
            $display("FAIL longse0_strobes: got %0d expected 0", got_q.size() - base + eop_cnt - e0 + err_cnt - r0); else passed++;
        send_sync();
        send_byte(8'h3C, 1'b0);
        send_eop();
        b = (got_q.size() > base) ? got_q[base] : 8'hxx;
        checks++; if (b !== 8'h3C) $display("FAIL longse0_next_byte: got %h expected 3c", b); else passed++;
        checks++; if (eop_cnt - e0 !== 1) $display("FAIL longse0_next_eop: got %0d expected 1", eop_cnt - e0); else passed++;
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_line_state();
        test_clean_packet();
        test_stuffing();
        test_truncated();
        test_short_sync();
        test_reset_abort();
        test_enable_abort();
        test_long_se0();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
